// File: rtl/rf_text_screen_ram2.sv
// Dual-port text-screen RAM: a handshaked bus port A with byte writes, a free-running
// video read port B, and a whole-memory fill engine sharing the write path with port A.
module rf_text_screen_ram2 #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8192,
    parameter int RD_LAT     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     csa_i,
    input  logic                     wea_i,
    input  logic [DATA_WIDTH/8-1:0]  sela_i,
    input  logic [$clog2(DEPTH)-1:0] adra_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     acka_o,
    input  logic                     csb_i,
    input  logic [$clog2(DEPTH)-1:0] adrb_i,
    output logic [DATA_WIDTH-1:0]    datb_o,
    output logic                     vldb_o,
    input  logic                     fill_req_i,
    input  logic [DATA_WIDTH-1:0]    fill_val_i,
    output logic                     fill_busy_o,
    output logic                     fill_done_o
);
    localparam int   AW   = $clog2(DEPTH);
    localparam int   BW   = DATA_WIDTH / 8;
    localparam logic LAT1 = (RD_LAT == 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ABUSY = 2'd1, FILL = 2'd2, DONE = 2'd3} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [DATA_WIDTH-1:0] fill_val_q;
    logic                  fill_busy_q, fill_busy_d;
    logic                  fill_done_q, fill_done_d;
    logic                  acka_q;
    logic [DATA_WIDTH-1:0] data_q, a1_data_q;
    logic                  a1_vld_q;
    logic [DATA_WIDTH-1:0] datb_q, b1_data_q;
    logic                  vldb_q, b1_vld_q;
    logic                  acc_s, acc_wr_s, acc_rd_s;

    // Fill requests take priority over the bus in IDLE; reset blocks acceptance.
    assign acc_s    = rst_ni && (state_q == IDLE) && !fill_req_i && csa_i;
    assign acc_wr_s = acc_s && wea_i;
    assign acc_rd_s = acc_s && !wea_i;

    // State and fill bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fill_cnt_q  <= {AW{1'b0}};
            fill_val_q  <= {DATA_WIDTH{1'b0}};
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_busy_q <= fill_busy_d;
            fill_done_q <= fill_done_d;
            if (state_q == IDLE && fill_req_i) begin
                fill_val_q <= fill_val_i;
            end
        end
    end

    // Next-state logic; the fill ends when the word counter is about to wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fill_req_i) begin
                    state_d = FILL;
                end else if (csa_i) begin
                    state_d = ABUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            ABUSY: begin
                if (acka_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = ABUSY;
                end
            end
            FILL: begin
                if (&fill_cnt_q) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and counter decode from the next state so the flags come out registered.
    always_comb begin
        fill_busy_d = 1'b0;
        fill_done_d = 1'b0;
        fill_cnt_d  = {AW{1'b0}};
        if (state_q == FILL) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
        end else begin
            fill_cnt_d = {AW{1'b0}};
        end
        if (state_d == FILL) begin
            fill_busy_d = 1'b1;
        end else begin
            fill_busy_d = 1'b0;
        end
        if (state_d == DONE) begin
            fill_done_d = 1'b1;
        end else begin
            fill_done_d = 1'b0;
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (state_q == FILL) begin
            mem_q[fill_cnt_q] <= fill_val_q;
        end else if (acc_wr_s) begin
            for (int b = 0; b < BW; b++) begin
                if (sela_i[b]) begin
                    mem_q[adra_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    // Port A completion pipeline; data_o only changes when a read completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acka_q    <= 1'b0;
            data_q    <= {DATA_WIDTH{1'b0}};
            a1_data_q <= {DATA_WIDTH{1'b0}};
            a1_vld_q  <= 1'b0;
        end else begin
            acka_q   <= 1'b0;
            a1_vld_q <= 1'b0;
            if (acc_wr_s) begin
                acka_q <= 1'b1;
            end else if (acc_rd_s && LAT1) begin
                acka_q <= 1'b1;
                data_q <= mem_q[adra_i];
            end else if (acc_rd_s) begin
                a1_vld_q  <= 1'b1;
                a1_data_q <= mem_q[adra_i];
            end
            if (a1_vld_q) begin
                acka_q <= 1'b1;
                data_q <= a1_data_q;
            end
        end
    end

    // Port B read pipeline, read-first against same-cycle writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            datb_q    <= {DATA_WIDTH{1'b0}};
            vldb_q    <= 1'b0;
            b1_data_q <= {DATA_WIDTH{1'b0}};
            b1_vld_q  <= 1'b0;
        end else begin
            b1_vld_q <= 1'b0;
            vldb_q   <= 1'b0;
            if (csb_i && LAT1) begin
                vldb_q <= 1'b1;
                datb_q <= mem_q[adrb_i];
            end else if (csb_i) begin
                b1_vld_q  <= 1'b1;
                b1_data_q <= mem_q[adrb_i];
            end
            if (b1_vld_q) begin
                vldb_q <= 1'b1;
                datb_q <= b1_data_q;
            end
        end
    end

    assign data_o      = data_q;
    assign acka_o      = acka_q;
    assign datb_o      = datb_q;
    assign vldb_o      = vldb_q;
    assign fill_busy_o = fill_busy_q;
    assign fill_done_o = fill_done_q;

endmodule
